// File: rtl/mips_loader_pkg.sv
// Shared types and helpers for the MIPS32 byte-stream program loader.
// LOADER_CHECKSUM_EN adds the XOR trailer check state.
package mips_loader_pkg;

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_WORD,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_START,
    S_DONE,
    S_ERR
  } state_e;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  function automatic logic count_ok(
    input logic [15:0] n,
    input int unsigned depth
  );
    return (n != 16'd0) && (32'(n) <= depth);
  endfunction

endpackage

// File: rtl/mips_word_assembler.sv
// Big-endian byte-to-word assembler for the program loader.
// Emits a word combinationally alongside every 4th accepted byte.
module mips_word_assembler
  import mips_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [23:0] sh_q;
  logic [1:0]  idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      idx_q <= '0;
    end else if (clr_i) begin
      idx_q <= '0;
    end else if (byte_valid_i) begin
      sh_q  <= {sh_q[15:0], byte_i};
      idx_q <= idx_q + 2'd1;
    end
  end

  assign word_valid_o = byte_valid_i &&
                        (idx_q == 2'(WORD_BYTES - 1));
  assign word_o       = {sh_q, byte_i};

endmodule

// File: rtl/mips_prog_loader.sv
// Length-prefixed byte-stream loader for the MIPS32 instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module mips_prog_loader
  import mips_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              core_start,
  output logic              done,
  output logic              err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_e            state_q, state_d;
  logic [7:0]        hi_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [31:0]       wdata_q;
  logic              acc;
  logic              wv;
  logic [31:0]       word;
  logic [15:0]       n;

  assign acc = in_valid && in_ready;
  assign n   = {hi_q, in_data};

  mips_word_assembler u_asm (
    .clk          (clk1),
    .rst_n        (rst_n),
    .clr_i        (acc && state_q == S_HDR_LO),
    .byte_valid_i (acc && state_q == S_WORD),
    .byte_i       (in_data),
    .word_valid_o (wv),
    .word_o       (word)
  );

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] xor_q;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      xor_q <= '0;
    end else if (acc) begin
      xor_q <= (state_q == S_HDR_HI) ?
               in_data : (xor_q ^ in_data);
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    last_d     = last_q;
    in_ready   = 1'b0;
    core_start = 1'b0;
    unique case (state_q)
      S_HDR_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_HDR_LO;
      end
      S_HDR_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (!count_ok(n, DEPTH)) begin
            state_d = S_ERR;
          end else begin
            addr_d  = '0;
            last_d  = ADDR_W'(n - 16'd1);
            state_d = S_WORD;
          end
        end
      end
      S_WORD: begin
        in_ready = 1'b1;
        if (wv) begin
          if (addr_q == last_q) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = S_CHK;
`else
            state_d = S_START;
`endif
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = (in_data == xor_q) ?
                    S_START : S_ERR;
        end
      end
`endif
      // the final write must land before the core runs
      S_START: begin
        if (!we_q) begin
          core_start = 1'b1;
          state_d    = S_DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HDR_HI;
      hi_q    <= '0;
      addr_q  <= '0;
      last_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      we_q    <= wv;
      if (acc && state_q == S_HDR_HI) hi_q <= in_data;
      if (wv) begin
        waddr_q <= addr_q;
        wdata_q <= word;
      end
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = waddr_q;
  assign mem_wdata = wdata_q;
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_ERR);
  assign core_hold = !(core_start || done);

endmodule

// File: doc/mips_prog_loader.md
# mips_prog_loader

Byte-stream program loader for the pipelined MIPS32 core. It accepts a length-prefixed byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them to consecutive instruction-memory addresses from 0. It holds the core halted during loading and pulses a start strobe when loading completes. This lets the core be loaded by hardware instead of direct memory pokes.

## Interface
- ADDR_W, 10, instruction-memory word-address width; capacity DEPTH = 2**ADDR_W words
- clk1  in  1  core clock, phase 1; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input byte valid
- in_data  in  8  input byte
- in_ready  out  1  loader accepts a byte this cycle; transfer occurs when in_valid && in_ready
- mem_we  out  1  single-cycle instruction-memory write strobe
- mem_addr  out  ADDR_W  word address of the write
- mem_wdata  out  32  instruction word
- core_hold  out  1  drives the core's HALTED; 1 while loading
- core_start  out  1  one-cycle pulse; the core clears PC and TAKEN_BRANCH and leaves halt on it
- done  out  1  sticky, program loaded and started
- err  out  1  sticky, bad header or checksum; core never started

## Operation
- Stream format:
  - Word count N: 16 bits, MSB byte first.
  - N words of 4 bytes each, MSB byte first.
  - Optional checksum byte (see Configuration).
- States and transitions:
  - HDR_HI: accept count[15:8], go to HDR_LO.
  - HDR_LO: accept count[7:0]. If N==0 or N>DEPTH, go to ERR. Otherwise clear byte index and word address, go to WORD.
  - WORD: accept bytes, shifting into a 32-bit register. On the 4th byte, register a write for the current address. On the last word, go to CHK if configured, else START. Otherwise increment the address.
  - CHK: accept one byte. On match go to START, else go to ERR.
  - START: core_start=1 for one cycle, core_hold drops to 0, go to DONE.
  - DONE: terminal. in_ready=0, done=1.
  - ERR: terminal. in_ready=0, err=1, core_hold stays 1.
- Only reset leaves DONE or ERR.
- in_ready=1 exactly in HDR_HI, HDR_LO, WORD and CHK. It does not depend on in_valid.
- The write is registered. mem_addr and mem_wdata are stable in the cycle mem_we=1, and a new byte may be accepted in that same cycle.
- Word address arithmetic is ADDR_W-bit with no wrap. Because N≤DEPTH, the last address is DEPTH-1 at most.
- Bytes offered with in_valid=1 while in_ready=0 are ignored and not consumed.

## Timing
- Reset values:
  - in_ready=1 (state HDR_HI)
  - mem_we=0, mem_addr=0, mem_wdata=0
  - core_hold=1, core_start=0, done=0, err=0
- Write latency: mem_we pulses the cycle after the 4th byte of a word is accepted.
- Start latency, no checksum: core_start pulses 2 cycles after the last data byte is accepted (one cycle after the final mem_we).
- Start latency, with checksum: core_start pulses 1 cycle after the checksum byte is accepted.
- Best-case throughput is 1 byte per cycle, with no bubbles at word boundaries.
- Reset mid-load:
  - All state returns to HDR_HI and core_hold reasserts.
  - Words already written are not cleared.
  - Any pending write is dropped.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - The stream carries one trailing byte equal to the XOR of all header and data bytes.
  - The CHK state exists. A mismatch goes to ERR.
- LOADER_CHECKSUM_EN undefined:
  - No trailer byte is expected and the CHK state and XOR register are absent.
  - The last data byte leads directly to START.

## Structure
- Package mips_loader_pkg holds:
  - the state enum
  - constants HDR_BYTES=2 and WORD_BYTES=4
  - function for the capacity check
- Sub-module mips_word_assembler: a shift register plus 2-bit byte index that emits word_valid with a 32-bit word on every 4th accepted byte. The top level owns the FSM, address counter, write register and checksum.

## Test plan
- Load the 9-word program (N=0x0009; words 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 00222000, 0ce77800, 00832800, fc000000) at one byte per cycle. Required response:
  - 9 writes, addr 0 = 2801000a through addr 8 = fc000000.
  - core_start pulses once, 2 cycles after the last byte.
  - done=1, core_hold=0.
  - Once the core runs, R4=30 and R5=55.
- Same stream with in_valid toggled randomly -> identical write sequence. No byte is lost or duplicated.
- Header 0x0000 -> err=1 after HDR_LO, no mem_we, core_hold stays 1, in_ready=0.
- Header N=DEPTH+1 (0x0401 with ADDR_W=10) -> err=1, no writes. N=0x0400 with 1024 words -> last write at addr 0x3FF, done=1.
- Assert rst_n=0 after the 2nd byte of word 3 -> outputs return to their reset values. A fresh 1-word stream (0x0001, fc000000) then writes addr 0 and starts the core.
- With LOADER_CHECKSUM_EN: a correct XOR trailer -> done=1. A trailer with bit 0 flipped -> err=1, no core_start.
